// File: rtl/zoom_frame_scheduler_if.sv
// Control, command and status bundle between the zoom scheduler and its neighbours.
// The master side is the scheduler; the slave side is the selection logic / scaling engine.
interface zoom_frame_scheduler_if;
    logic        START;
    logic        ABORT;
    logic [1:0]  ALGORITHM;
    logic [1:0]  SHIFT_FACTOR;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [7:0]  CMD_SRC_X;
    logic [6:0]  CMD_SRC_Y;
    logic [18:0] CMD_DST_ADDR;
    logic        CMD_LAST;
    logic        ENGINE_BUSY;
    logic [10:0] OUT_WIDTH;
    logic [9:0]  OUT_HEIGHT;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;

    modport master (
        input  START, ABORT, ALGORITHM, SHIFT_FACTOR, CMD_READY, ENGINE_BUSY,
        output CMD_VALID, CMD_SRC_X, CMD_SRC_Y, CMD_DST_ADDR, CMD_LAST,
               OUT_WIDTH, OUT_HEIGHT, BUSY, DONE, ERROR
    );

    modport slave (
        output START, ABORT, ALGORITHM, SHIFT_FACTOR, CMD_READY, ENGINE_BUSY,
        input  CMD_VALID, CMD_SRC_X, CMD_SRC_Y, CMD_DST_ADDR, CMD_LAST,
               OUT_WIDTH, OUT_HEIGHT, BUSY, DONE, ERROR
    );
endinterface

// File: rtl/zoom_frame_scheduler.sv
// Walks the output raster of one zoom/decimation pass, one engine command per output pixel.
// First command 2 cycles after START, then 1/cycle; fields held while CMD_READY is low.
module zoom_frame_scheduler #(
    parameter int IMG_WIDTH_IN  = 160,
    parameter int IMG_HEIGHT_IN = 120,
    parameter int MAX_UP_SHIFT  = 2,
    parameter int MAX_DN_SHIFT  = 3
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    zoom_frame_scheduler_if.master  bus
);
    localparam logic [10:0] IN_W = 11'(IMG_WIDTH_IN);
    localparam logic [9:0]  IN_H = 10'(IMG_HEIGHT_IN);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic        dn_q, dn_d;
    logic [1:0]  shift_q, shift_d;
    logic [10:0] out_w_q, out_w_d;
    logic [9:0]  out_h_q, out_h_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [18:0] addr_q, addr_d;
    logic [7:0]  src_x_q, src_x_d;
    logic [6:0]  src_y_q, src_y_d;
    logic        vld_q, vld_d;
    logic        last_q, last_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        start_dn, start_legal, accept, x_wrap, load_cmd;
    logic [10:0] nx, w_use;
    logic [9:0]  ny, h_use;

    always_comb begin
        state_d  = state_q;
        dn_d     = dn_q;
        shift_d  = shift_q;
        out_w_d  = out_w_q;
        out_h_d  = out_h_q;
        x_d      = x_q;
        y_d      = y_q;
        addr_d   = addr_q;
        src_x_d  = src_x_q;
        src_y_d  = src_y_q;
        vld_d    = vld_q;
        last_d   = last_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        load_cmd = 1'b0;
        nx       = x_q;
        ny       = y_q;
        w_use    = out_w_q;
        h_use    = out_h_q;

        start_dn    = bus.ALGORITHM[1];
        start_legal = start_dn ? ({1'b0, bus.SHIFT_FACTOR} <= 3'(MAX_DN_SHIFT))
                               : ({1'b0, bus.SHIFT_FACTOR} <= 3'(MAX_UP_SHIFT));
        accept      = vld_q & bus.CMD_READY;
        x_wrap      = (x_q == out_w_q - 11'd1);

        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    if (start_legal) begin
                        state_d = S_SETUP;
                        dn_d    = start_dn;
                        shift_d = bus.SHIFT_FACTOR;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                out_w_d  = dn_q ? (IN_W >> shift_q) : (IN_W << shift_q);
                out_h_d  = dn_q ? (IN_H >> shift_q) : (IN_H << shift_q);
                w_use    = out_w_d;
                h_use    = out_h_d;
                nx       = 11'd0;
                ny       = 10'd0;
                addr_d   = 19'd0;
                load_cmd = 1'b1;
                vld_d    = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (accept) begin
                    if (last_q) begin
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        state_d = S_DRAIN;
                    end else begin
                        // Raster walk by increment: address tracks y*W+x without a multiplier.
                        nx       = x_wrap ? 11'd0 : x_q + 11'd1;
                        ny       = x_wrap ? y_q + 10'd1 : y_q;
                        addr_d   = addr_q + 19'd1;
                        load_cmd = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // DONE is raised while still in DRAIN so BUSY covers the DONE cycle.
                if (done_q)
                    state_d = S_IDLE;
                else if (!bus.ENGINE_BUSY)
                    done_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (load_cmd) begin
            x_d     = nx;
            y_d     = ny;
            src_x_d = dn_q ? 8'(nx << shift_q) : 8'(nx >> shift_q);
            src_y_d = dn_q ? 7'(ny << shift_q) : 7'(ny >> shift_q);
            last_d  = (nx == w_use - 11'd1) && (ny == h_use - 10'd1);
        end

        if (bus.ABORT && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            dn_q    <= 1'b0;
            shift_q <= 2'd0;
            out_w_q <= IN_W;
            out_h_q <= IN_H;
            x_q     <= 11'd0;
            y_q     <= 10'd0;
            addr_q  <= 19'd0;
            src_x_q <= 8'd0;
            src_y_q <= 7'd0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dn_q    <= dn_d;
            shift_q <= shift_d;
            out_w_q <= out_w_d;
            out_h_q <= out_h_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            src_x_q <= src_x_d;
            src_y_q <= src_y_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign bus.CMD_VALID    = vld_q;
    assign bus.CMD_SRC_X    = src_x_q;
    assign bus.CMD_SRC_Y    = src_y_q;
    assign bus.CMD_DST_ADDR = addr_q;
    assign bus.CMD_LAST     = last_q;
    assign bus.OUT_WIDTH    = out_w_q;
    assign bus.OUT_HEIGHT   = out_h_q;
    assign bus.BUSY         = (state_q != S_IDLE);
    assign bus.DONE         = done_q;
    assign bus.ERROR        = error_q;
endmodule

// File: tb/tb_zoom_frame_scheduler.sv
// Bench for zoom_frame_scheduler: table of directed passes plus hand-written reset/abort sequences.
module tb_zoom_frame_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    zoom_frame_scheduler_if bus();

    zoom_frame_scheduler dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus.master)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] alg;
        logic [1:0] sh;
        bit         rnd;
        int         abort_at;
        int         eb_hold;
        bit         exp_err;
        int         exp_w;
        int         exp_h;
        int         probe;
        int         px;
        int         py;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    int r_cmds, r_bad, r_stall_bad, r_done, r_last_pos, r_abort_vld, r_abort_busy;
    int r_timeout, r_busy_end, r_busy_at_done, r_vld_late, done_cyc, eb_fall_cyc;
    int r_px, r_py, r_pa, bad_idx;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic run_pass(input vec_t v);
        int budget, ph, post, eb_cnt, n_exp, ex, ey, ax, ay;
        bit stall_prev, rdy, fin;
        logic [7:0]  hx;
        logic [6:0]  hy;
        logic [18:0] ha;
        logic        hl;
        r_cmds = 0; r_bad = 0; r_stall_bad = 0; r_done = 0; r_last_pos = -1;
        r_abort_vld = -1; r_abort_busy = -1; r_timeout = 0; r_busy_end = -1;
        r_busy_at_done = -1; r_vld_late = 0; done_cyc = -1; eb_fall_cyc = -1;
        r_px = -1; r_py = -1; r_pa = -1; bad_idx = -1;
        hx = '0; hy = '0; ha = '0; hl = 1'b0;
        n_exp  = v.exp_w * v.exp_h;
        budget = ((v.abort_at >= 0) ? v.abort_at : n_exp) * (v.rnd ? 4 : 1) + 100;
        ph = 0; post = 0; fin = 1'b0; stall_prev = 1'b0; eb_cnt = 0;
        @(negedge clk);
        bus.ALGORITHM    = v.alg;
        bus.SHIFT_FACTOR = v.sh;
        bus.START        = 1'b1;
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            @(negedge clk);
            bus.START = 1'b0;
            if (bus.DONE) begin
                r_done++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    r_busy_at_done = bus.BUSY;
                end
            end
            if (stall_prev && !(bus.CMD_VALID && bus.CMD_SRC_X == hx && bus.CMD_SRC_Y == hy &&
                                bus.CMD_DST_ADDR == ha && bus.CMD_LAST == hl))
                r_stall_bad++;
            stall_prev = 1'b0;
            case (ph)
                0: begin
                    rdy = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    bus.CMD_READY = rdy;
                    if (bus.CMD_VALID && v.abort_at >= 0 && r_cmds == v.abort_at) begin
                        bus.ABORT     = 1'b1;
                        bus.CMD_READY = 1'b1;
                        ph = 3;
                    end else if (bus.CMD_VALID && rdy) begin
                        ex = r_cmds % v.exp_w;
                        ey = r_cmds / v.exp_w;
                        ax = (v.alg[1] ? (ex << v.sh) : (ex >> v.sh)) & 'hFF;
                        ay = (v.alg[1] ? (ey << v.sh) : (ey >> v.sh)) & 'h7F;
                        if (bus.CMD_SRC_X != ax || bus.CMD_SRC_Y != ay || bus.CMD_DST_ADDR != r_cmds ||
                            bus.CMD_LAST != (r_cmds == n_exp - 1)) begin
                            if (r_bad == 0) bad_idx = r_cmds;
                            r_bad++;
                        end
                        if (r_cmds == v.probe) begin
                            r_px = bus.CMD_SRC_X;
                            r_py = bus.CMD_SRC_Y;
                            r_pa = bus.CMD_DST_ADDR;
                        end
                        r_cmds++;
                        if (bus.CMD_LAST) begin
                            ph = 1;
                            r_last_pos = r_cmds;
                            eb_cnt = v.eb_hold;
                            bus.ENGINE_BUSY = (v.eb_hold > 0);
                        end
                    end else if (bus.CMD_VALID) begin
                        stall_prev = 1'b1;
                        hx = bus.CMD_SRC_X; hy = bus.CMD_SRC_Y;
                        ha = bus.CMD_DST_ADDR; hl = bus.CMD_LAST;
                    end
                end
                1: begin
                    if (bus.CMD_VALID) r_vld_late++;
                    if (eb_cnt > 0) begin
                        eb_cnt--;
                        if (eb_cnt == 0) begin
                            bus.ENGINE_BUSY = 1'b0;
                            eb_fall_cyc = cyc;
                        end
                    end
                    if (done_cyc >= 0) begin
                        ph = 2;
                        post = 4;
                    end
                end
                2: begin
                    if (bus.CMD_VALID) r_vld_late++;
                    post--;
                    if (post == 0) begin
                        r_busy_end = bus.BUSY;
                        fin = 1'b1;
                    end
                end
                default: begin
                    bus.ABORT    = 1'b0;
                    r_abort_vld  = bus.CMD_VALID;
                    r_abort_busy = bus.BUSY;
                    ph = 2;
                    post = 6;
                end
            endcase
        end
        if (!fin) r_timeout = 1;
        bus.CMD_READY   = 1'b0;
        bus.ENGINE_BUSY = 1'b0;
        bus.ABORT       = 1'b1;
        @(negedge clk);
        bus.ABORT       = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   n_exp, dn;
        rst_n = 1'b0;
        bus.START = 1'b0; bus.ABORT = 1'b0; bus.ALGORITHM = 2'd0; bus.SHIFT_FACTOR = 2'd0;
        bus.CMD_READY = 1'b0; bus.ENGINE_BUSY = 1'b0;

        //          alg   sh    rnd   abort eb  err   W    H    probe  px   py
        vecs[0] = '{2'd0, 2'd1, 1'b0, -1,   0, 1'b0, 320, 240, 76799, 159, 119};
        vecs[1] = '{2'd2, 2'd2, 1'b0, -1,   0, 1'b0, 40,  30,  41,    4,   4};
        vecs[2] = '{2'd1, 2'd3, 1'b0, -1,   0, 1'b1, 0,   0,   0,     0,   0};
        vecs[3] = '{2'd0, 2'd3, 1'b0, -1,   0, 1'b1, 0,   0,   0,     0,   0};
        vecs[4] = '{2'd3, 2'd3, 1'b1, -1,   5, 1'b0, 20,  15,  299,   152, 112};
        vecs[5] = '{2'd2, 2'd2, 1'b0, 100,  0, 1'b0, 40,  30,  99,    76,  8};
        vecs[6] = '{2'd0, 2'd0, 1'b0, 500,  0, 1'b0, 160, 120, 321,   1,   2};
        vecs[7] = '{2'd1, 2'd2, 1'b1, 2000, 0, 1'b0, 640, 480, 1000,  90,  0};
        vecs[8] = '{2'd2, 2'd1, 1'b1, 300,  0, 1'b0, 80,  60,  85,    10,  2};
        vecs[9] = '{2'd3, 2'd2, 1'b0, -1,   3, 1'b0, 40,  30,  1199,  156, 116};

        repeat (3) @(negedge clk);
        check("rst_valid", bus.CMD_VALID, 0);
        check("rst_last", bus.CMD_LAST, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_done", bus.DONE, 0);
        check("rst_error", bus.ERROR, 0);
        check("rst_src_x", bus.CMD_SRC_X, 0);
        check("rst_src_y", bus.CMD_SRC_Y, 0);
        check("rst_addr", bus.CMD_DST_ADDR, 0);
        check("rst_out_w", bus.OUT_WIDTH, 160);
        check("rst_out_h", bus.OUT_HEIGHT, 120);
        rst_n = 1'b1;

        @(negedge clk); bus.ABORT = 1'b1;
        @(negedge clk); bus.ABORT = 1'b0;
        check("idle_abort_busy", bus.BUSY, 0);
        @(negedge clk);
        check("idle_abort_done", bus.DONE, 0);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            if (v.exp_err) begin
                @(negedge clk);
                bus.ALGORITHM = v.alg; bus.SHIFT_FACTOR = v.sh; bus.START = 1'b1;
                @(negedge clk);
                bus.START = 1'b0;
                check($sformatf("v%0d_err_pulse", i), bus.ERROR, 1);
                check($sformatf("v%0d_err_busy", i), bus.BUSY, 0);
                @(negedge clk);
                check($sformatf("v%0d_err_clear", i), bus.ERROR, 0);
                check($sformatf("v%0d_err_busy2", i), bus.BUSY, 0);
            end else begin
                run_pass(v);
                n_exp = v.exp_w * v.exp_h;
                check($sformatf("v%0d_timeout", i), r_timeout, 0);
                check($sformatf("v%0d_cmds", i), r_cmds, (v.abort_at >= 0) ? v.abort_at : n_exp);
                check($sformatf("v%0d_stream_bad(first_idx=%0d)", i, bad_idx), r_bad, 0);
                check($sformatf("v%0d_stall_unstable", i), r_stall_bad, 0);
                check($sformatf("v%0d_out_w", i), bus.OUT_WIDTH, v.exp_w);
                check($sformatf("v%0d_out_h", i), bus.OUT_HEIGHT, v.exp_h);
                check($sformatf("v%0d_probe_x", i), r_px, v.px);
                check($sformatf("v%0d_probe_y", i), r_py, v.py);
                check($sformatf("v%0d_probe_addr", i), r_pa, v.probe);
                check($sformatf("v%0d_valid_late", i), r_vld_late, 0);
                check($sformatf("v%0d_busy_end", i), r_busy_end, 0);
                check($sformatf("v%0d_done_cnt", i), r_done, (v.abort_at >= 0) ? 0 : 1);
                if (v.abort_at >= 0) begin
                    check($sformatf("v%0d_abort_valid", i), r_abort_vld, 0);
                    check($sformatf("v%0d_abort_busy", i), r_abort_busy, 0);
                end else begin
                    check($sformatf("v%0d_last_pos", i), r_last_pos, n_exp);
                    check($sformatf("v%0d_busy_at_done", i), r_busy_at_done, 1);
                    if (v.eb_hold > 0)
                        check($sformatf("v%0d_done_after_eb", i), done_cyc, eb_fall_cyc + 1);
                end
            end
        end

        // START while running is ignored; reset mid-pass returns to reset values without DONE.
        @(negedge clk);
        bus.ALGORITHM = 2'd2; bus.SHIFT_FACTOR = 2'd2; bus.START = 1'b1; bus.CMD_READY = 1'b1;
        @(negedge clk); bus.START = 1'b0;
        repeat (10) @(negedge clk);
        bus.ALGORITHM = 2'd0; bus.SHIFT_FACTOR = 2'd1; bus.START = 1'b1;
        @(negedge clk); bus.START = 1'b0;
        @(negedge clk);
        check("busy_start_ignored_w", bus.OUT_WIDTH, 40);
        check("busy_mid", bus.BUSY, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.CMD_VALID, 0);
        check("midrst_busy", bus.BUSY, 0);
        check("midrst_out_w", bus.OUT_WIDTH, 160);
        check("midrst_addr", bus.CMD_DST_ADDR, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.CMD_READY = 1'b0;
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.DONE) dn++;
        end
        check("midrst_no_done", dn, 0);
        check("midrst_busy_after", bus.BUSY, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
